// File: rtl/node_injector_if.sv
// Shared flit type and the point-to-point circuit link between injector and router.
package noc_types;
  parameter int unsigned FlitWidth = 32;
  typedef logic [FlitWidth-1:0] flit_t;
endpackage

// Upstream side drives flit/enable; downstream answers with ack (circuit held) or rej.
interface node_port;
  noc_types::flit_t flit;
  logic             enable;
  logic             ack;
  logic             rej;

  modport up   (output flit, output enable, input ack, input rej);
  modport down (input flit, input enable, output ack, output rej);
endinterface

// File: rtl/node_injector.sv
// Source-side injector: buffers one PE message, opens a circuit with the header,
// streams the payload once acked, and replays from the buffer after a backoff on failure.
module node_injector #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ACK_TIMEOUT    = 16,
  parameter int unsigned BACKOFF_CYCLES = 4,
  parameter int unsigned MAX_RETRIES    = 3,
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  noc_types::flit_t  in_flit,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  node_port.up              port,
  output logic              sent,
  output logic              drop,
  output logic              trunc,
  output logic [RetryW-1:0] retries
);

  localparam int unsigned LenW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned TimW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned BoW  = $clog2(BACKOFF_CYCLES + 1);

  typedef enum logic [1:0] {StLoad, StReq, StStream, StBackoff} state_e;

  state_e            state_q, state_d;
  noc_types::flit_t  mem_q [DEPTH];
  noc_types::flit_t  mem_d [DEPTH];
  logic [LenW-1:0]   len_q, len_d;
  logic [PtrW-1:0]   rd_q, rd_d, rd_nxt;
  logic [TimW-1:0]   timer_q, timer_d;
  logic [BoW-1:0]    bo_q, bo_d;
  logic [RetryW-1:0] retries_q, retries_d;
  noc_types::flit_t  flit_q, flit_d;
  logic              enable_q, enable_d;
  logic              sent_q, sent_d;
  logic              drop_q, drop_d;
  logic              trunc_q, trunc_d;
  logic              xfer;
  logic              finish_ok;
  logic              fail;

  // Accept PE flits only while loading; held low during reset.
  assign in_ready = (state_q == StLoad) && !rst;
  assign xfer     = in_valid && in_ready;
  assign rd_nxt   = rd_q + PtrW'(1);

  // Next-state logic for the load / request / stream / backoff sequence.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    len_d     = len_q;
    rd_d      = rd_q;
    timer_d   = timer_q;
    bo_d      = bo_q;
    retries_d = retries_q;
    flit_d    = flit_q;
    enable_d  = enable_q;
    sent_d    = 1'b0;
    drop_d    = 1'b0;
    trunc_d   = 1'b0;
    finish_ok = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (xfer) begin
          mem_d[PtrW'(len_q)] = in_flit;
          len_d               = len_q + LenW'(1);
          // The DEPTH-th flit closes the message even without in_last.
          if (in_last || (len_q == LenW'(DEPTH - 1))) begin
            trunc_d  = !in_last;
            state_d  = StReq;
            enable_d = 1'b1;
            flit_d   = mem_d[0];
            timer_d  = '0;
            rd_d     = '0;
          end
        end
      end
      StReq: begin
        if (port.rej) begin
          fail = 1'b1;
        end else if (port.ack) begin
          if (len_q == LenW'(1)) begin
            finish_ok = 1'b1;
          end else begin
            state_d = StStream;
            rd_d    = PtrW'(1);
            flit_d  = mem_q[1];
          end
        end else if (timer_q == TimW'(ACK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end
      StStream: begin
        // Ack must stay up for every flit, the last one included.
        if (port.rej || !port.ack) begin
          fail = 1'b1;
        end else if (LenW'(rd_q) == len_q - LenW'(1)) begin
          finish_ok = 1'b1;
        end else begin
          rd_d   = rd_nxt;
          flit_d = mem_q[rd_nxt];
        end
      end
      StBackoff: begin
        if (bo_q == BoW'(BACKOFF_CYCLES - 1)) begin
          state_d  = StReq;
          enable_d = 1'b1;
          flit_d   = mem_q[0];
          timer_d  = '0;
        end else begin
          bo_d = bo_q + BoW'(1);
        end
      end
      default: ;
    endcase

    if (finish_ok) begin
      enable_d  = 1'b0;
      sent_d    = 1'b1;
      state_d   = StLoad;
      len_d     = '0;
      rd_d      = '0;
      retries_d = '0;
    end

    if (fail) begin
      enable_d = 1'b0;
      rd_d     = '0;
      if (retries_q < RetryW'(MAX_RETRIES)) begin
        retries_d = retries_q + RetryW'(1);
        bo_d      = '0;
        state_d   = StBackoff;
      end else begin
        drop_d    = 1'b1;
        len_d     = '0;
        retries_d = '0;
        state_d   = StLoad;
      end
    end
  end

  // Control state and registered link outputs; reset aborts any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      len_q     <= '0;
      rd_q      <= '0;
      timer_q   <= '0;
      bo_q      <= '0;
      retries_q <= '0;
      flit_q    <= '0;
      enable_q  <= 1'b0;
      sent_q    <= 1'b0;
      drop_q    <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_q      <= rd_d;
      timer_q   <= timer_d;
      bo_q      <= bo_d;
      retries_q <= retries_d;
      flit_q    <= flit_d;
      enable_q  <= enable_d;
      sent_q    <= sent_d;
      drop_q    <= drop_d;
      trunc_q   <= trunc_d;
    end
  end

  // Message storage; contents are only meaningful below len_q, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign port.flit   = flit_q;
  assign port.enable = enable_q;
  assign sent        = sent_q;
  assign drop        = drop_q;
  assign trunc       = trunc_q;
  assign retries     = retries_q;

endmodule

// File: tb/tb_node_injector.sv
// Bench for node_injector: directed scenarios plus random messages and downstream
// behaviour, checked cycle by cycle against a trace predicted from the link rules.
module tb_node_injector;

  localparam int unsigned DEPTH          = 8;
  localparam int unsigned ACK_TIMEOUT    = 16;
  localparam int unsigned BACKOFF_CYCLES = 4;
  localparam int unsigned MAX_RETRIES    = 3;
  localparam int unsigned RW             = $clog2(MAX_RETRIES + 1);

  typedef noc_types::flit_t flit_t;
  typedef struct packed {
    logic          en;
    flit_t         flit;
    logic          sent;
    logic          drop;
    logic          trunc;
    logic [RW-1:0] retries;
    logic          rdy;
  } sig_t;
  typedef struct { sig_t s; bit ack; bit rej; } cyc_t;
  // a: first cycle of the attempt with ack held (-1 never); r: rej pulse cycle; g: ack gap cycle
  typedef struct { int a; int r; int g; } plan_t;

  logic          clk = 1'b0;
  logic          rst;
  flit_t         in_flit;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          sent;
  logic          drop;
  logic          trunc;
  logic [RW-1:0] retries;

  node_port port_if ();

  node_injector #(
    .DEPTH          (DEPTH),
    .ACK_TIMEOUT    (ACK_TIMEOUT),
    .BACKOFF_CYCLES (BACKOFF_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .port     (port_if),
    .sent     (sent),
    .drop     (drop),
    .trunc    (trunc),
    .retries  (retries)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  cyc_t trace_q[$];
  sig_t obs_q[$];
  sig_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    port_if.ack = 1'($urandom);
    port_if.rej = 1'($urandom);
  endtask

  function automatic sig_t sample();
    sig_t s;
    s.en      = port_if.enable;
    s.flit    = port_if.enable ? port_if.flit : '0;
    s.sent    = sent;
    s.drop    = drop;
    s.trunc   = trunc;
    s.retries = retries;
    s.rdy     = in_ready;
    return s;
  endfunction

  function automatic sig_t idle_sig(input bit rdy);
    sig_t s;
    s     = '0;
    s.rdy = rdy;
    return s;
  endfunction

  // Reference: expected link behaviour from the cycle after the last PE flit is taken.
  task automatic build_trace(input flit_t msg[$], input bit tr, input plan_t plans[$]);
    int   n;
    int   j;
    bit   done;
    n    = msg.size();
    j    = 0;
    done = 0;
    trace_q.delete();
    while (!done) begin
      plan_t p;
      int    c;
      int    k;
      bit    streaming;
      int    outcome;
      bit    ackv;
      bit    rejv;
      cyc_t  e;
      if (j < plans.size()) p = plans[j];
      else begin p.a = -1; p.r = -1; p.g = -1; end
      c = 0; k = 0; streaming = 0; outcome = 0;
      while (outcome == 0) begin
        ackv = (p.a >= 0) && (c >= p.a) && (c != p.g);
        rejv = (c == p.r);
        e.s         = '0;
        e.s.en      = 1'b1;
        e.s.flit    = msg[k];
        e.s.trunc   = tr && (j == 0) && (c == 0);
        e.s.retries = RW'(j);
        e.ack       = ackv;
        e.rej       = rejv;
        trace_q.push_back(e);
        if (rejv) outcome = 2;
        else if (!streaming) begin
          if (ackv) begin
            if (n == 1) outcome = 1;
            else begin streaming = 1; k = 1; end
          end else if (c == int'(ACK_TIMEOUT) - 1) outcome = 2;
        end else if (!ackv) outcome = 2;
        else if (k == n - 1) outcome = 1;
        else k++;
        c++;
      end
      e.ack = 0;
      e.rej = 0;
      if (outcome == 1) begin
        e.s = idle_sig(1); e.s.sent = 1'b1;
        trace_q.push_back(e);
        done = 1;
      end else if (j < int'(MAX_RETRIES)) begin
        for (int b = 0; b < int'(BACKOFF_CYCLES); b++) begin
          e.s = idle_sig(0); e.s.retries = RW'(j + 1);
          trace_q.push_back(e);
        end
        j++;
      end else begin
        e.s = idle_sig(1); e.s.drop = 1'b1;
        trace_q.push_back(e);
        done = 1;
      end
    end
  endtask

  // Load msg from the PE side with random gaps, then play the downstream side of trace_q.
  task automatic play(input flit_t msg[$], input bit tr);
    int gaps;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < msg.size(); i++) begin
      gaps = $urandom_range(0, 1);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0; in_last = 1'b0; in_flit = flit_t'($urandom); noise();
        obs_q.push_back(sample()); exp_q.push_back(idle_sig(1));
        tick();
      end
      in_valid = 1'b1;
      in_flit  = msg[i];
      in_last  = (i == msg.size() - 1) && !tr;
      noise();
      obs_q.push_back(sample()); exp_q.push_back(idle_sig(1));
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    foreach (trace_q[i]) begin
      if (trace_q[i].s.en) begin
        port_if.ack = trace_q[i].ack;
        port_if.rej = trace_q[i].rej;
      end else noise();
      obs_q.push_back(sample()); exp_q.push_back(trace_q[i].s);
      tick();
    end
    port_if.ack = 1'b0;
    port_if.rej = 1'b0;
  endtask

  function automatic plan_t mk(input int a, input int r, input int g);
    plan_t p;
    p.a = a; p.r = r; p.g = g;
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_flit = '0;
    port_if.ack = 1'b0; port_if.rej = 1'b0;
    tick(); tick();
    vectors++;
    if (port_if.enable !== 1'b0 || port_if.flit !== '0) begin
      miscompares++;
      $display("FAIL reset_link: got enable=%b flit=%h, expected 0 0", port_if.enable, port_if.flit);
    end
    vectors++;
    if ({in_ready, sent, drop, trunc} !== 4'b0 || retries !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got rdy/sent/drop/trunc=%b retries=%0d, expected 0000 0",
               {in_ready, sent, drop, trunc}, retries);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || port_if.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b enable=%b, expected 1 0", in_ready, port_if.enable);
    end
  endtask

  task automatic test_four_flit();
    flit_t msg[$];
    plan_t plans[$];
    msg   = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    plans = '{mk(1, -1, -1)};
    build_trace(msg, 0, plans);
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL four_flit cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_flit();
    flit_t msg[$];
    plan_t plans[$];
    msg   = '{32'h5151_0001};
    plans = '{mk(0, -1, -1)};
    build_trace(msg, 0, plans);
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_flit cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rej_retry();
    flit_t msg[$];
    plan_t plans[$];
    msg   = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
    plans = '{mk(0, 1, -1), mk(0, -1, -1)};
    build_trace(msg, 0, plans);
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rej_retry cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    flit_t msg[$];
    plan_t plans[$];
    msg = '{32'hD0D0_0000, 32'hD0D0_0001};
    build_trace(msg, 0, plans);
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL drop cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_trunc();
    flit_t msg[$];
    flit_t rest[$];
    plan_t plans[$];
    for (int i = 0; i < 10; i++) begin
      if (i < int'(DEPTH)) msg.push_back(flit_t'(32'hE000_0000 + i));
      else rest.push_back(flit_t'(32'hE000_0000 + i));
    end
    plans = '{mk(0, -1, -1)};
    build_trace(msg, 1, plans);
    play(msg, 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL trunc_head cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
    build_trace(rest, 0, plans);
    play(rest, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL trunc_tail cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ack_rej_together();
    flit_t msg[$];
    plan_t plans[$];
    msg   = '{32'hBEEF_0000, 32'hBEEF_0001};
    plans = '{mk(0, 0, -1), mk(0, -1, -1)};
    build_trace(msg, 0, plans);
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ack_rej_together cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    flit_t msg[$];
    plan_t plans[$];
    msg   = '{32'h7E57_0000, 32'h7E57_0001, 32'h7E57_0002, 32'h7E57_0003};
    plans = '{mk(0, -1, -1)};
    build_trace(msg, 0, plans);
    while (trace_q.size() > 3) void'(trace_q.pop_back());
    play(msg, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_stream_pre cycle %0d: got %p, expected %p", i, obs_q[i], exp_q[i]);
      end
    end
    // Last flit on the link with ack held; reset lands in the same cycle.
    port_if.ack = 1'b1;
    port_if.rej = 1'b0;
    rst = 1'b1;
    tick();
    port_if.ack = 1'b0;
    vectors++;
    if ({port_if.enable, sent, drop, in_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_stream_abort: got en/sent/drop/rdy=%b, expected 0000",
               {port_if.enable, sent, drop, in_ready});
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({port_if.enable, sent, drop, in_ready} !== 4'b0001 || retries !== '0) begin
      miscompares++;
      $display("FAIL reset_stream_after: got en/sent/drop/rdy=%b retries=%0d, expected 0001 0",
               {port_if.enable, sent, drop, in_ready}, retries);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int    len;
      int    pos;
      flit_t msg[$];
      len = $urandom_range(1, DEPTH + 3);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(flit_t'($urandom));
      pos = 0;
      while (pos < len) begin
        flit_t chunk[$];
        plan_t plans[$];
        int    m;
        bit    tr;
        int    kind;
        tr = (len - pos) > int'(DEPTH);
        m  = tr ? int'(DEPTH) : (len - pos);
        chunk.delete();
        plans.delete();
        for (int i = 0; i < m; i++) chunk.push_back(msg[pos + i]);
        for (int j = 0; j <= int'(MAX_RETRIES); j++) begin
          int a;
          kind = $urandom_range(0, 5);
          a    = $urandom_range(0, 3);
          case (kind)
            1: plans.push_back(mk(-1, -1, -1));
            2: plans.push_back(mk(-1, $urandom_range(0, ACK_TIMEOUT - 1), -1));
            3: plans.push_back(mk(a, a + $urandom_range(0, m), -1));
            4: plans.push_back(mk(a, -1, a + $urandom_range(1, m)));
            default: plans.push_back(mk($urandom_range(0, ACK_TIMEOUT + 2), -1, -1));
          endcase
        end
        build_trace(chunk, tr, plans);
        play(chunk, tr);
        for (int i = 0; i < obs_q.size(); i++) begin
          vectors++;
          if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL random msg %0d cycle %0d: got %p, expected %p", t, i, obs_q[i], exp_q[i]);
          end
        end
        pos += m;
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_flit();
    test_single_flit();
    test_rej_retry();
    test_drop();
    test_trunc();
    test_ack_rej_together();
    test_reset_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
